// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and data width.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous pins; reset value is a parameter
// so idle-high lines do not show a false edge coming out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first one a full cycle to resolve.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, one-cycle valid / error strobes.
// Build option: define UART_RX_PARITY_EN to add a parity bit between data and stop
// (sense chosen by PARITY_ODD); without it parity_err_o is tied low.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line high, waiting for a falling edge on rx_s
// START     | counting to mid start bit; still low -> DATA, else glitch
// DATA      | sampling 8 data bits LSB-first, one per bit period
// PARITY    | sampling the parity bit (UART_RX_PARITY_EN builds only)
// STOP      | sampling the stop bit at mid-bit; deliver byte or flag error
// WAIT_HIGH | after a framing error, hold off until the line returns high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 4,
    parameter int PARITY_ODD      = 0
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BAUD) + 1;
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLOCKS_PER_BAUD - 1) / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    if (CLOCKS_PER_BAUD < 2 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
        $error("uart_rx: CLOCKS_PER_BAUD must be >= 2 and PARITY_ODD must be 0 or 1");
    end

    logic              rx_s;
    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              perr_q, perr_d;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
    logic              par_bad_q, par_bad_d;
`endif

    sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .d_i       (rx_i),
        .q_o       (rx_s)
    );

    // State, timer, shifter and registered output strobes.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next-state logic; the bit timer is a down-counter acting on terminal count 0.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else if (!rx_s) begin
                    cnt_d   = FULL;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    cnt_d   = FULL;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    par_bad_d = (rx_s != ((^shift_q) ^ PAR_SENSE));
                    cnt_d     = FULL;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else if (rx_s) begin
                    // Leave at mid stop bit so a back-to-back start edge is caught.
                    state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                    if (par_bad_q) begin
                        perr_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end
`else
                    valid_d = 1'b1;
                    data_d  = shift_q;
`endif
                end else begin
                    // A bad stop bit outranks any parity result.
                    ferr_d  = 1'b1;
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven on rx_i, the expected strobe for each
// frame is queued at drive time and popped when the DUT pulses an output.
module tb_uart_rx;

    localparam int CPB  = 4;
    localparam int HALF = (CPB - 1) / 2;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // rx_i low before edge 1 -> rx_s low after edge 2 -> FSM sees it at edge 3 (= t);
    // the stop bit is sampled, and valid_o registered, at t+1+HALF+(9+NPAR)*CPB.
    localparam int LAT = 3 + 1 + HALF + (9 + NPAR) * CPB;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_FERR  = 3'b010;
    localparam logic [2:0] K_PERR  = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    logic       clock_i = 1'b0;
    logic       reset_n_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       busy_o;

    exp_t       sb[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_valid_cyc = 0;
    int         start_cyc = 0;
    int         gap_cnt = 0;
    int         last_gap = 0;
    bit         gap_arm = 1'b0;
    logic [7:0] good_data = 8'h00;
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    uart_rx #(
        .CLOCKS_PER_BAUD (CPB),
        .PARITY_ODD      (PODD)
    ) dut (
        .clock_i      (clock_i),
        .reset_n_i    (reset_n_i),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .busy_o       (busy_o)
    );

    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock_i);
    endtask

    task automatic push(input logic [2:0] kind, input logic [7:0] d);
        exp_t x;
        x.kind = kind;
        x.data = d;
        sb.push_back(x);
    endtask

    // Leaves rx_i at the stop-bit level so a following call is back-to-back.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx_i = (^d) ^ PODD[0] ^ par_flip;
        tick(CPB);
`endif
        rx_i = stop_bit;
        tick(CPB);
    endtask

    // Scoreboard side: every strobe must match the oldest queued expectation.
    always @(negedge clock_i) begin
        if (valid_o || frame_err_o || parity_err_o) begin
            chk("pulse_expected", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pulse_kind", {29'd0, valid_o, frame_err_o, parity_err_o}, {29'd0, e.kind});
                chk("pulse_data", {24'd0, data_o}, {24'd0, e.data});
            end
            if (valid_o) last_valid_cyc = cyc;
        end
        if (valid_o) begin
            gap_arm = 1'b1;
            gap_cnt = 0;
        end
        if (gap_arm) begin
            if (!busy_o) begin
                gap_cnt++;
            end else begin
                gap_arm  = 1'b0;
                last_gap = gap_cnt;
            end
        end
    end

    initial begin
        rx_i      = 1'b1;
        reset_n_i = 1'b0;
        tick(3);
        chk("rst_data", {24'd0, data_o}, 32'h00);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err_o}, 32'd0);
        chk("rst_perr", {31'd0, parity_err_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        reset_n_i = 1'b1;
        tick(2);

        // Single good frame, latency from rx_i fall to valid_o.
        push(K_VALID, 8'hA5);
        good_data = 8'hA5;
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        tick(4);
        chk("a5_latency", last_valid_cyc - start_cyc, LAT);
        chk("a5_idle", {31'd0, busy_o}, 32'd0);

        // Back-to-back frames.
        push(K_VALID, 8'h00);
        push(K_VALID, 8'hFF);
        good_data = 8'hFF;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(6);
        chk("b2b_gap_le2", {31'd0, (last_gap >= 1 && last_gap <= 2)}, 32'd1);
        chk("b2b_data", {24'd0, data_o}, {24'd0, good_data});

        // One-cycle glitch on the idle line.
        rx_i = 1'b0;
        tick(1);
        rx_i = 1'b1;
        tick(2);
        chk("glitch_busy_hi", {31'd0, busy_o}, 32'd1);
        tick(HALF + 1);
        chk("glitch_busy_lo", {31'd0, busy_o}, 32'd0);
        tick(4);
        push(K_VALID, 8'h3C);
        good_data = 8'h3C;
        send_frame(8'h3C, 1'b1);
        tick(6);

        // Bad stop bit, then line held low; no retrigger until it rises.
        push(K_FERR, good_data);
        send_frame(8'h55, 1'b0);
        tick(40);
        chk("ferr_wait_busy", {31'd0, busy_o}, 32'd1);
        rx_i = 1'b1;
        tick(4);
        chk("ferr_released", {31'd0, busy_o}, 32'd0);
        chk("ferr_data_held", {24'd0, data_o}, {24'd0, good_data});
        push(K_VALID, 8'h3C);
        send_frame(8'h3C, 1'b1);
        tick(6);

        // Reset in the middle of data bit 4 of an aborted 0x5A frame.
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_i = (8'h5A >> i) & 8'h01;
            tick(CPB);
        end
        rx_i = 1'b1;
        tick(2);
        reset_n_i = 1'b0;
        tick(1);
        chk("midrst_data", {24'd0, data_o}, 32'h00);
        chk("midrst_valid", {31'd0, valid_o}, 32'd0);
        chk("midrst_ferr", {31'd0, frame_err_o}, 32'd0);
        chk("midrst_perr", {31'd0, parity_err_o}, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        tick(2);
        reset_n_i = 1'b1;
        good_data = 8'h00;
        tick(12 * CPB);
        chk("post_rst_data", {24'd0, data_o}, 32'h00);
        push(K_VALID, 8'h81);
        good_data = 8'h81;
        send_frame(8'h81, 1'b1);
        tick(6);
        chk("post_rst_81", {24'd0, data_o}, 32'h81);

`ifdef UART_RX_PARITY_EN
        push(K_VALID, 8'h07);
        good_data = 8'h07;
        par_flip  = 1'b0;
        send_frame(8'h07, 1'b1);
        tick(6);
        push(K_PERR, good_data);
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        tick(6);
        par_flip = 1'b0;
        chk("par_data_held", {24'd0, data_o}, 32'h07);
`endif

        tick(4);
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
